// File: rtl/dm_arb_pkg.sv
// Shared encodings for the data-memory arbiter: access sizes, byte-enable
// patterns and sequencer states.
package dm_arb_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned BE_W   = 4;
   localparam int unsigned SIZE_W = 2;

   localparam logic [SIZE_W-1:0] SZ_BYTE = 2'b00;
   localparam logic [SIZE_W-1:0] SZ_HALF = 2'b01;
   localparam logic [SIZE_W-1:0] SZ_WORD = 2'b10;
   localparam logic [SIZE_W-1:0] SZ_ILL  = 2'b11;

   localparam logic [BE_W-1:0] BE_NONE = 4'b0000;
   localparam logic [BE_W-1:0] BE_B0   = 4'b0001;
   localparam logic [BE_W-1:0] BE_LO   = 4'b0011;
   localparam logic [BE_W-1:0] BE_HI   = 4'b1100;
   localparam logic [BE_W-1:0] BE_WORD = 4'b1111;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

endpackage

// File: rtl/dm_lane_ctl.sv
// Byte-lane control for one DM access: derives the byte enable and the
// misalignment flag from size + low address bits, and extracts the load
// data from the addressed lane(s), right-justified and zero-extended.
module dm_lane_ctl
   import dm_arb_pkg::*;
(
   input  logic [SIZE_W-1:0] i_size,
   input  logic [1:0]        i_off,
   input  logic [DATA_W-1:0] i_rd,
   output logic [BE_W-1:0]   o_be_c,
   output logic              o_misalign_c,
   output logic [DATA_W-1:0] o_rdata_c
);

   // Byte enable and alignment check; an illegal size enables no lanes
   always_comb begin
      o_be_c       = BE_NONE;
      o_misalign_c = 1'b0;
      case (i_size)
         SZ_BYTE: o_be_c = BE_B0 << i_off;
         SZ_HALF: begin
            o_be_c       = i_off[1] ? BE_HI : BE_LO;
            o_misalign_c = i_off[0];
         end
         SZ_WORD: begin
            o_be_c       = BE_WORD;
            o_misalign_c = |i_off;
         end
         default: ;
      endcase
   end

   // Load lane extraction from the raw DM word
   always_comb begin
      o_rdata_c = '0;
      case (i_size)
         SZ_BYTE: o_rdata_c = DATA_W'(i_rd[{i_off, 3'b000} +: 8]);
         SZ_HALF: o_rdata_c = i_off[1] ? DATA_W'(i_rd[31:16]) : DATA_W'(i_rd[15:0]);
         SZ_WORD: o_rdata_c = i_rd;
         default: ;
      endcase
   end

endmodule

// File: rtl/dm_arbiter.sv
// Two-master arbiter and sequencer for the single-port data memory.
// Master 0 is the CPU MEM stage, master 1 the DMA/peripheral bridge.
// Each transaction runs IDLE (grant) -> ACCESS (DM cycle) -> RESP (ack).
// Build option DM_ARB_FIXED_PRIO_EN: master 0 always wins ties instead of
// round-robin.
module dm_arbiter
   import dm_arb_pkg::*;
#(
   parameter int unsigned DM_AW  = 12,
   parameter int unsigned ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [SIZE_W-1:0] m0_size,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_ack,
   output logic              m0_err,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [SIZE_W-1:0] m1_size,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_ack,
   output logic              m1_err,
   output logic [DATA_W-1:0] m1_rdata,
   output logic [DATA_W-1:0] dm_A,
   output logic              dm_MemWrite,
   output logic [DATA_W-1:0] dm_WD,
   output logic [BE_W-1:0]   dm_BE,
   input  logic [DATA_W-1:0] dm_RD
);

   state_t              r_state;
   state_t              w_state_nxt;

   logic                r_gnt;
   logic                r_we;
   logic [SIZE_W-1:0]   r_size;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;

   logic                r_m0_ack;
   logic                r_m0_err;
   logic [DATA_W-1:0]   r_m0_rdata;
   logic                r_m1_ack;
   logic                r_m1_err;
   logic [DATA_W-1:0]   r_m1_rdata;

   logic                w_gnt_vld;
   logic                w_gnt_sel;
   logic [BE_W-1:0]     w_be;
   logic                w_misalign;
   logic                w_oor;
   logic                w_err;
   logic [DATA_W-1:0]   w_rdata;
   logic                w_access;

   assign w_gnt_vld = m0_req | m1_req;

`ifdef DM_ARB_FIXED_PRIO_EN
   // Fixed priority: master 0 wins whenever it requests
   assign w_gnt_sel = ~m0_req;
`else
   logic r_last_grant;

   // Remember the last winner; reset value lets master 0 take the first tie
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_last_grant <= 1'b1;
      end else if (r_state == ST_IDLE && w_gnt_vld) begin
         r_last_grant <= w_gnt_sel;
      end
   end

   // Round-robin: on a tie, grant the master that did not win last time
   assign w_gnt_sel = (m0_req & m1_req) ? ~r_last_grant : m1_req;
`endif

   // Sequencer state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state: ACCESS and RESP each last exactly one cycle
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:   if (w_gnt_vld) w_state_nxt = ST_ACCESS;
         ST_ACCESS: w_state_nxt = ST_RESP;
         ST_RESP:   w_state_nxt = ST_IDLE;
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   dm_lane_ctl u_lane_ctl (
      .i_size       (r_size),
      .i_off        (r_addr[1:0]),
      .i_rd         (dm_RD),
      .o_be_c       (w_be),
      .o_misalign_c (w_misalign),
      .o_rdata_c    (w_rdata)
   );

   // Anything above the DM's byte range is out of range
   assign w_oor    = |r_addr[ADDR_W-1:DM_AW+2];
   assign w_err    = w_misalign | (r_size == SZ_ILL) | w_oor;
   assign w_access = (r_state == ST_ACCESS);

   // DM port is driven straight from the command register; a faulting
   // access never writes and enables no lanes
   assign dm_A        = DATA_W'({r_addr[ADDR_W-1:2], 2'b00});
   assign dm_WD       = r_wdata;
   assign dm_BE       = (w_access && !w_err) ? w_be : BE_NONE;
   assign dm_MemWrite = w_access & r_we & ~w_err;

   // Command capture on grant, read-data capture and ack/err generation
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_gnt      <= 1'b0;
         r_we       <= 1'b0;
         r_size     <= SZ_BYTE;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_m0_ack   <= 1'b0;
         r_m0_err   <= 1'b0;
         r_m0_rdata <= '0;
         r_m1_ack   <= 1'b0;
         r_m1_err   <= 1'b0;
         r_m1_rdata <= '0;
      end else begin
         r_m0_ack <= 1'b0;
         r_m0_err <= 1'b0;
         r_m1_ack <= 1'b0;
         r_m1_err <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_gnt_vld) begin
                  r_gnt   <= w_gnt_sel;
                  r_we    <= w_gnt_sel ? m1_we    : m0_we;
                  r_size  <= w_gnt_sel ? m1_size  : m0_size;
                  r_addr  <= w_gnt_sel ? m1_addr  : m0_addr;
                  r_wdata <= w_gnt_sel ? m1_wdata : m0_wdata;
               end
            end
            ST_ACCESS: begin
               if (r_gnt) begin
                  r_m1_ack <= 1'b1;
                  r_m1_err <= w_err;
                  if (w_err)      r_m1_rdata <= '0;
                  else if (!r_we) r_m1_rdata <= w_rdata;
               end else begin
                  r_m0_ack <= 1'b1;
                  r_m0_err <= w_err;
                  if (w_err)      r_m0_rdata <= '0;
                  else if (!r_we) r_m0_rdata <= w_rdata;
               end
            end
            default: ;
         endcase
      end
   end

   assign m0_ack   = r_m0_ack;
   assign m0_err   = r_m0_err;
   assign m0_rdata = r_m0_rdata;
   assign m1_ack   = r_m1_ack;
   assign m1_err   = r_m1_err;
   assign m1_rdata = r_m1_rdata;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed testbench for dm_arbiter with a behavioural 4096 x 32 data memory.
module tb_dm_arbiter;

   logic        clk;
   logic        reset_n;
   logic        m0_req, m0_we, m1_req, m1_we;
   logic [1:0]  m0_size, m1_size;
   logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
   logic        m0_ack, m0_err, m1_ack, m1_err;
   logic [31:0] m0_rdata, m1_rdata;
   logic [31:0] dm_A, dm_WD, dm_RD;
   logic        dm_MemWrite;
   logic [3:0]  dm_BE;

   int checks;
   int failures;

   logic [31:0] mem [4096];

   // Per-transaction observations
   logic        t_mw;
   logic [3:0]  t_be;
   logic [31:0] t_a, t_wd, t_rdata;
   int          t_lat;
   logic        t_err, t_other, t_after;

   dm_arbiter dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .m0_req      (m0_req),
      .m0_we       (m0_we),
      .m0_size     (m0_size),
      .m0_addr     (m0_addr),
      .m0_wdata    (m0_wdata),
      .m0_ack      (m0_ack),
      .m0_err      (m0_err),
      .m0_rdata    (m0_rdata),
      .m1_req      (m1_req),
      .m1_we       (m1_we),
      .m1_size     (m1_size),
      .m1_addr     (m1_addr),
      .m1_wdata    (m1_wdata),
      .m1_ack      (m1_ack),
      .m1_err      (m1_err),
      .m1_rdata    (m1_rdata),
      .dm_A        (dm_A),
      .dm_MemWrite (dm_MemWrite),
      .dm_WD       (dm_WD),
      .dm_BE       (dm_BE),
      .dm_RD       (dm_RD)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Data memory: combinational read, byte-enabled write on the rising edge
   assign dm_RD = mem[dm_A[13:2]];
   always @(posedge clk) begin
      if (dm_MemWrite) begin
         for (int b = 0; b < 4; b++)
            if (dm_BE[b]) mem[dm_A[13:2]][8*b +: 8] <= dm_WD[8*b +: 8];
      end
   end

   // Drives one transaction from master m and records what was seen; starts
   // and ends 1 ns after a rising edge with the arbiter in IDLE
   task automatic run_txn(input int m, input logic we, input logic [1:0] sz,
                          input logic [31:0] addr, input logic [31:0] wdata);
      if (m == 0) begin
         m0_req = 1'b1; m0_we = we; m0_size = sz; m0_addr = addr; m0_wdata = wdata;
      end else begin
         m1_req = 1'b1; m1_we = we; m1_size = sz; m1_addr = addr; m1_wdata = wdata;
      end
      t_lat = -1; t_err = 1'bx; t_rdata = 'x; t_other = 1'b0;
      @(posedge clk); #1;
      t_mw = dm_MemWrite; t_be = dm_BE; t_a = dm_A; t_wd = dm_WD;
      t_other = (m == 0) ? (m1_ack | m1_err) : (m0_ack | m0_err);
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk); #1;
         t_other = t_other | ((m == 0) ? (m1_ack | m1_err) : (m0_ack | m0_err));
         if (((m == 0) ? m0_ack : m1_ack) === 1'b1) begin
            t_lat   = k;
            t_err   = (m == 0) ? m0_err : m1_err;
            t_rdata = (m == 0) ? m0_rdata : m1_rdata;
            break;
         end
      end
      m0_req = 1'b0; m1_req = 1'b0;
      @(posedge clk); #1;
      t_after = m0_ack | m1_ack | m0_err | m1_err;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      m0_req = 0; m0_we = 0; m0_size = 0; m0_addr = 0; m0_wdata = 0;
      m1_req = 0; m1_we = 0; m1_size = 0; m1_addr = 0; m1_wdata = 0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({m0_ack, m0_err, m1_ack, m1_err, dm_MemWrite} !== 5'b0) begin
         failures++;
         $display("FAIL reset_flags: got %b expected 00000", {m0_ack, m0_err, m1_ack, m1_err, dm_MemWrite});
      end
      checks++;
      if ({dm_A, dm_WD, dm_BE} !== 68'h0) begin
         failures++;
         $display("FAIL reset_dm_port: got A=%h WD=%h BE=%b expected all zero", dm_A, dm_WD, dm_BE);
      end
      checks++;
      if ({m0_rdata, m1_rdata} !== 64'h0) begin
         failures++;
         $display("FAIL reset_rdata: got %h %h expected 0 0", m0_rdata, m1_rdata);
      end
      reset_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_round_robin();
      int order[6];
      int n;
      int exp;
      n = 0;
      m0_req = 1; m0_we = 0; m0_size = 2'b10; m0_addr = 32'h100; m0_wdata = 0;
      m1_req = 1; m1_we = 0; m1_size = 2'b10; m1_addr = 32'h104; m1_wdata = 0;
      for (int c = 0; c < 40 && n < 6; c++) begin
         @(posedge clk); #1;
         if (m0_ack && m1_ack) begin
            order[n] = 9; n++;
         end else if (m0_ack) begin
            order[n] = 0; n++;
         end else if (m1_ack) begin
            order[n] = 1; n++;
         end
      end
      m0_req = 0; m1_req = 0;
      @(posedge clk); #1;
      checks++;
      if (n != 6) begin
         failures++;
         $display("FAIL rr_count: got %0d acks expected 6", n);
      end
      for (int i = 0; i < n; i++) begin
`ifdef DM_ARB_FIXED_PRIO_EN
         exp = 0;
`else
         exp = i % 2;
`endif
         checks++;
         if (order[i] != exp) begin
            failures++;
            $display("FAIL rr_grant%0d: got master %0d expected %0d", i, order[i], exp);
         end
      end
   endtask

   task automatic test_word();
      run_txn(0, 1'b1, 2'b10, 32'h10, 32'h12345678);
      checks++;
      if ({t_mw, t_be, t_a, t_wd} !== {1'b1, 4'b1111, 32'h10, 32'h12345678}) begin
         failures++;
         $display("FAIL sw_access: got mw=%b be=%b A=%h WD=%h expected 1 1111 00000010 12345678", t_mw, t_be, t_a, t_wd);
      end
      checks++;
      if (t_lat != 1 || t_err !== 1'b0 || t_other !== 1'b0 || t_after !== 1'b0) begin
         failures++;
         $display("FAIL sw_ack: got lat=%0d err=%b other=%b after=%b expected 1 0 0 0", t_lat, t_err, t_other, t_after);
      end
      checks++;
      if (mem[4] !== 32'h12345678) begin
         failures++;
         $display("FAIL sw_mem: got %h expected 12345678", mem[4]);
      end
      run_txn(0, 1'b0, 2'b10, 32'h10, 32'h0);
      checks++;
      if (t_mw !== 1'b0 || t_lat != 1 || t_err !== 1'b0 || t_rdata !== 32'h12345678) begin
         failures++;
         $display("FAIL lw: got mw=%b lat=%0d err=%b rdata=%h expected 0 1 0 12345678", t_mw, t_lat, t_err, t_rdata);
      end
      run_txn(0, 1'b0, 2'b01, 32'h12, 32'h0);
      checks++;
      if (t_be !== 4'b1100 || t_err !== 1'b0 || t_rdata !== 32'h00001234) begin
         failures++;
         $display("FAIL lh_hi: got be=%b err=%b rdata=%h expected 1100 0 00001234", t_be, t_err, t_rdata);
      end
   endtask

   task automatic test_byte_half();
      run_txn(1, 1'b1, 2'b00, 32'h23, 32'hABABABAB);
      checks++;
      if ({t_mw, t_be, t_a, t_wd} !== {1'b1, 4'b1000, 32'h20, 32'hABABABAB}) begin
         failures++;
         $display("FAIL sb_access: got mw=%b be=%b A=%h WD=%h expected 1 1000 00000020 abababab", t_mw, t_be, t_a, t_wd);
      end
      checks++;
      if (mem[8] !== 32'hAB000000 || t_lat != 1 || t_err !== 1'b0 || t_other !== 1'b0) begin
         failures++;
         $display("FAIL sb_mem: got mem=%h lat=%0d err=%b other=%b expected ab000000 1 0 0", mem[8], t_lat, t_err, t_other);
      end
      run_txn(1, 1'b0, 2'b01, 32'h22, 32'h0);
      checks++;
      if (t_be !== 4'b1100 || t_err !== 1'b0 || t_rdata !== 32'h0000AB00) begin
         failures++;
         $display("FAIL lh: got be=%b err=%b rdata=%h expected 1100 0 0000ab00", t_be, t_err, t_rdata);
      end
      run_txn(1, 1'b0, 2'b00, 32'h13, 32'h0);
      checks++;
      if (t_be !== 4'b1000 || t_rdata !== 32'h00000012) begin
         failures++;
         $display("FAIL lb: got be=%b rdata=%h expected 1000 00000012", t_be, t_rdata);
      end
   endtask

   task automatic test_errors();
      run_txn(0, 1'b0, 2'b10, 32'h02, 32'h0);
      checks++;
      if (t_lat != 1 || t_err !== 1'b1 || t_mw !== 1'b0 || t_be !== 4'b0000 || t_rdata !== 32'h0) begin
         failures++;
         $display("FAIL err_lw_misalign: got lat=%0d err=%b mw=%b be=%b rdata=%h expected 1 1 0 0000 0", t_lat, t_err, t_mw, t_be, t_rdata);
      end
      run_txn(1, 1'b1, 2'b01, 32'h01, 32'h0000FFFF);
      checks++;
      if (t_lat != 1 || t_err !== 1'b1 || t_mw !== 1'b0 || t_rdata !== 32'h0 || mem[0] !== 32'h0) begin
         failures++;
         $display("FAIL err_sh_misalign: got lat=%0d err=%b mw=%b rdata=%h mem=%h expected 1 1 0 0 0", t_lat, t_err, t_mw, t_rdata, mem[0]);
      end
      run_txn(0, 1'b1, 2'b10, 32'h4000, 32'hDEADBEEF);
      checks++;
      if (t_lat != 1 || t_err !== 1'b1 || t_mw !== 1'b0 || t_be !== 4'b0000 || mem[0] !== 32'h0) begin
         failures++;
         $display("FAIL err_oor: got lat=%0d err=%b mw=%b be=%b mem=%h expected 1 1 0 0000 0", t_lat, t_err, t_mw, t_be, mem[0]);
      end
      checks++;
      if (t_other !== 1'b0 || t_after !== 1'b0) begin
         failures++;
         $display("FAIL err_oor_pulse: got other=%b after=%b expected 0 0", t_other, t_after);
      end
   endtask

   task automatic test_illegal_size();
      run_txn(0, 1'b0, 2'b11, 32'h10, 32'h0);
      checks++;
      if (t_lat != 1 || t_err !== 1'b1 || t_be !== 4'b0000 || t_rdata !== 32'h0) begin
         failures++;
         $display("FAIL illegal_size: got lat=%0d err=%b be=%b rdata=%h expected 1 1 0000 0", t_lat, t_err, t_be, t_rdata);
      end
   endtask

   task automatic test_reset_mid();
      logic seen_ack;
      int   first;
      m0_req = 1; m0_we = 1; m0_size = 2'b10; m0_addr = 32'h40; m0_wdata = 32'hCAFEF00D;
      @(posedge clk); #1;
      checks++;
      if (dm_MemWrite !== 1'b1) begin
         failures++;
         $display("FAIL rst_mid_pre: got mw=%b expected 1", dm_MemWrite);
      end
      reset_n = 1'b0;
      #1;
      checks++;
      if (dm_MemWrite !== 1'b0 || dm_BE !== 4'b0000) begin
         failures++;
         $display("FAIL rst_mid_drop: got mw=%b be=%b expected 0 0000", dm_MemWrite, dm_BE);
      end
      m0_req = 0;
      seen_ack = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         seen_ack = seen_ack | m0_ack | m1_ack;
      end
      checks++;
      if (seen_ack !== 1'b0 || mem[16] !== 32'h0) begin
         failures++;
         $display("FAIL rst_mid_abandon: got ack=%b mem=%h expected 0 0", seen_ack, mem[16]);
      end
      reset_n = 1'b1;
      @(posedge clk); #1;
      m0_req = 1; m0_we = 0; m0_size = 2'b10; m0_addr = 32'h10;
      m1_req = 1; m1_we = 0; m1_size = 2'b10; m1_addr = 32'h20;
      first = -1;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         if (m0_ack || m1_ack) begin
            first = m0_ack ? 0 : 1;
            break;
         end
      end
      m0_req = 0; m1_req = 0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (first != 0) begin
         failures++;
         $display("FAIL rst_first_tie: got master %0d expected 0", first);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
      test_reset();
      test_round_robin();
      test_word();
      test_byte_half();
      test_errors();
      test_illegal_size();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
